// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - default geometry of the UART receive buffer
package uart_rx_fifo_pkg;

    // Byte width produced by uart_rx
    localparam int UART_DATA_BITS_DEFAULT  = 8;
    // 16-entry buffer by default
    localparam int UART_DEPTH_LOG2_DEFAULT = 4;
    // Supported depth range (2 .. 1024 entries)
    localparam int UART_DEPTH_LOG2_MIN     = 1;
    localparam int UART_DEPTH_LOG2_MAX     = 10;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - FIFO storage, sync write port and async read port
module fifo_mem #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_BITS-1:0]  wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_BITS-1:0]  rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Write port: storage is never reset so it can map to distributed RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is combinational to give first-word-fall-through at the top
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte buffer behind uart_rx with occupancy and sticky overflow
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  wr_en,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // One extra pointer bit separates the full and empty cases
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                push;
    logic                pop;
    logic                drop;

    // Flags decode only the registered pointers, so inputs cannot glitch them
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == DEPTH_CNT);
        empty    = (count == '0);
        rd_valid = !empty;
        overflow = overflow_q;
    end

    // A pop frees a slot in the same cycle, so a write to a full FIFO with a pop is accepted
    always_comb begin
        pop  = rd_ready & rd_valid;
        push = wr_en & (!full | pop);
        drop = wr_en & full & !pop;
    end

    // Next-state for pointers and the sticky overflow flag (a new drop beats a clear)
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control state; reset discards everything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    fifo_mem #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(
        .DATA_BITS  (8),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill16(input logic [7:0] base);
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = base + 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    logic [7:0] lb_bytes [5];

    initial begin
        lb_bytes[0] = 8'h55; lb_bytes[1] = 8'hC3; lb_bytes[2] = 8'h0D;
        lb_bytes[3] = 8'h7E; lb_bytes[4] = 8'hA0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        // 1: three writes, visible one cycle after the first, then read in order
        wr_en = 1'b1; wr_data = 8'h41;
        tick();
        check("t1_valid", rd_valid, 1);
        check("t1_head", rd_data, 8'h41);
        wr_data = 8'h42;
        tick();
        wr_data = 8'h43;
        tick();
        wr_en = 1'b0;
        check("t1_count3", count, 3);
        check("t1_head_stable", rd_data, 8'h41);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_read", rd_data, 8'h41 + i);
            tick();
        end
        rd_ready = 1'b0;
        check("t1_empty", empty, 1);
        check("t1_valid0", rd_valid, 0);

        // 2: fill to full, drop the 17th byte
        fill16(8'h00);
        check("t2_full", full, 1);
        check("t2_count16", count, 16);
        check("t2_ovf_pre", overflow, 0);
        wr_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("t2_ovf", overflow, 1);
        check("t2_count_hold", count, 16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_drain", rd_data, i);
            tick();
        end
        rd_ready = 1'b0;
        check("t2_empty", empty, 1);

        // 5a: clear the sticky flag
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr", overflow, 0);

        // 3: write and pop together while full is accepted
        fill16(8'h10);
        wr_en = 1'b1; wr_data = 8'hAA; rd_ready = 1'b1;
        tick();
        wr_en = 1'b0; rd_ready = 1'b0;
        check("t3_ovf", overflow, 0);
        check("t3_count16", count, 16);
        check("t3_full", full, 1);
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("t3_drain", rd_data, 8'h10 + i);
            tick();
        end
        check("t3_last", rd_data, 8'hAA);
        tick();
        rd_ready = 1'b0;
        check("t3_empty", empty, 1);

        // 4: stream 40 bytes through across pointer wraps
        wr_en = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'h80 + 8'(i);
            tick();
            check("t4_count", count, 1);
            check("t4_data", rd_data, 8'h80 + i);
        end
        wr_en = 1'b0;
        tick();
        rd_ready = 1'b0;
        check("t4_empty", empty, 1);
        check("t4_ovf", overflow, 0);

        // 5b: clear coinciding with a drop keeps overflow set
        fill16(8'h20);
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        check("t5_set", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        check("t5_set_wins", overflow, 1);
        wr_en = 1'b0;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr2", overflow, 0);
        check("t5_count16", count, 16);

        // 6: async reset mid-operation takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_valid", rd_valid, 0);
        check("t6_rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 6: bytes arriving at serial pace, consumer stalled, then released
        for (int b = 0; b < 5; b++) begin
            wr_en = 1'b1; wr_data = lb_bytes[b];
            tick();
            wr_en = 1'b0;
            if (b == 0) check("t6_first", rd_data, 8'h55);
            for (int k = 0; k < 9; k++) tick();
        end
        check("t6_count5", count, 5);
        rd_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            check("t6_order", rd_data, lb_bytes[b]);
            tick();
        end
        rd_ready = 1'b0;
        check("t6_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
